// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the M20K port arbiter.
// The byte-to-bit mask expansion is used only when MEM_ARB_WMASK_EN is defined.
package mem_arb_pkg;

    localparam int unsigned RD_LATENCY = 1;
    localparam logic        CLI0       = 1'b0;
    localparam logic        CLI1       = 1'b1;
    localparam int unsigned MAX_DW     = 64;

    localparam logic [MAX_DW-1:0] WEM_ALL_ONES = '1;

    // Replicate each byte-enable bit across its eight data bits.
    function automatic logic [MAX_DW-1:0] be_to_mask(input logic [MAX_DW/8-1:0] be);
        logic [MAX_DW-1:0] m;
        m = '0;
        for (int i = 0; i < int'(MAX_DW / 8); i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// Per-client read response FIFO with occupancy count.
// Simultaneous push and pop leaves the count unchanged.
module mem_rsp_fifo #(
    parameter int unsigned DW    = 32,
    parameter int unsigned RSP_D = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [DW-1:0]          din_i,
    input  logic                   pop_i,
    output logic [DW-1:0]          dout_o,
    output logic [$clog2(RSP_D):0] cnt_o
);

    localparam int unsigned PW = $clog2(RSP_D);
    localparam int unsigned CW = PW + 1;

    logic [DW-1:0] mem_q [RSP_D];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !pop_i) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push_i && pop_i) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + PW'(1);
            if (pop_i)  rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end

    // Data storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

    assign dout_o = mem_q[rd_q];
    assign cnt_o  = cnt_q;

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop_i && (cnt_q == CW'(RSP_D))));
    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(pop_i && (cnt_q == '0)));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for two valid/ready clients onto one M20K port, with per-client read response buffers.
// Define MEM_ARB_WMASK_EN to add REQ_BE0/1 byte enables driving the macro bit write mask.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW    = 9,
    parameter int unsigned DW    = 32,
    parameter int unsigned RSP_D = 2
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            REQ_VALID0,
    output logic            REQ_READY0,
    input  logic            REQ_WE0,
    input  logic [AW-1:0]   REQ_ADDR0,
    input  logic [DW-1:0]   REQ_DATA0,
`ifdef MEM_ARB_WMASK_EN
    input  logic [DW/8-1:0] REQ_BE0,
    input  logic [DW/8-1:0] REQ_BE1,
`endif
    input  logic            REQ_VALID1,
    output logic            REQ_READY1,
    input  logic            REQ_WE1,
    input  logic [AW-1:0]   REQ_ADDR1,
    input  logic [DW-1:0]   REQ_DATA1,
    output logic            RSP_VALID0,
    input  logic            RSP_READY0,
    output logic [DW-1:0]   RSP_DATA0,
    output logic            RSP_VALID1,
    input  logic            RSP_READY1,
    output logic [DW-1:0]   RSP_DATA1,
    output logic [AW-1:0]   A,
    output logic [DW-1:0]   D,
    output logic            CE,
    output logic            WE,
    output logic [DW-1:0]   WEM,
    input  logic [DW-1:0]   Q
);

    localparam int unsigned CW  = $clog2(RSP_D) + 1;
    localparam int unsigned CW1 = CW + RD_LATENCY;

    logic          inflight_q, inflight_d;
    logic          owner_q,    owner_d;
    logic          last_q,     last_d;

    logic [CW-1:0] cnt0_c, cnt1_c;
    logic [DW-1:0] head0_c, head1_c;
    logic          infl0_c, infl1_c;
    logic          elig0_c, elig1_c;
    logic          req0_c, req1_c;
    logic          gnt0_c, gnt1_c;
    logic          push0_c, push1_c;
    logic          pop0_c, pop1_c;

    // Read credits: buffered entries plus the one read whose data is still on its way.
    assign infl0_c = inflight_q && (owner_q == CLI0);
    assign infl1_c = inflight_q && (owner_q == CLI1);
    assign elig0_c = REQ_WE0 || ((CW1'(cnt0_c) + CW1'(infl0_c)) < CW1'(RSP_D));
    assign elig1_c = REQ_WE1 || ((CW1'(cnt1_c) + CW1'(infl1_c)) < CW1'(RSP_D));

    // Reset blocks grants so the macro sees CE=0 while RSTN is low.
    assign req0_c = RSTN && REQ_VALID0 && elig0_c;
    assign req1_c = RSTN && REQ_VALID1 && elig1_c;
    assign gnt0_c = req0_c && (!req1_c || (last_q == CLI1));
    assign gnt1_c = req1_c && !gnt0_c;

    assign REQ_READY0 = gnt0_c;
    assign REQ_READY1 = gnt1_c;

    always_comb begin
        last_d     = last_q;
        owner_d    = owner_q;
        inflight_d = 1'b0;
        if (gnt0_c) begin
            last_d     = CLI0;
            owner_d    = CLI0;
            inflight_d = !REQ_WE0;
        end else if (gnt1_c) begin
            last_d     = CLI1;
            owner_d    = CLI1;
            inflight_d = !REQ_WE1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            inflight_q <= 1'b0;
            owner_q    <= CLI0;
            last_q     <= CLI1;
        end else begin
            inflight_q <= inflight_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        A  = '0;
        D  = '0;
        WE = 1'b0;
        if (gnt0_c) begin
            A  = REQ_ADDR0;
            D  = REQ_DATA0;
            WE = REQ_WE0;
        end else if (gnt1_c) begin
            A  = REQ_ADDR1;
            D  = REQ_DATA1;
            WE = REQ_WE1;
        end
    end

    assign CE = gnt0_c || gnt1_c;

`ifdef MEM_ARB_WMASK_EN
    localparam int unsigned BW_MAX = MAX_DW / 8;

    always_comb begin
        WEM = DW'(WEM_ALL_ONES);
        if (gnt0_c && REQ_WE0) begin
            WEM = DW'(be_to_mask(BW_MAX'(REQ_BE0)));
        end else if (gnt1_c && REQ_WE1) begin
            WEM = DW'(be_to_mask(BW_MAX'(REQ_BE1)));
        end
    end
`else
    assign WEM = DW'(WEM_ALL_ONES);
`endif

    // Q bypasses an empty buffer; it is only stored when the client cannot take it now.
    assign push0_c = infl0_c && !((cnt0_c == '0) && RSP_READY0);
    assign push1_c = infl1_c && !((cnt1_c == '0) && RSP_READY1);
    assign pop0_c  = (cnt0_c != '0) && RSP_READY0;
    assign pop1_c  = (cnt1_c != '0) && RSP_READY1;

    assign RSP_VALID0 = (cnt0_c != '0) || infl0_c;
    assign RSP_VALID1 = (cnt1_c != '0) || infl1_c;
    assign RSP_DATA0  = (cnt0_c != '0) ? head0_c : Q;
    assign RSP_DATA1  = (cnt1_c != '0) ? head1_c : Q;

    mem_rsp_fifo #(.DW(DW), .RSP_D(RSP_D)) u_rsp_fifo0 (
        .clk    (CLK),
        .rst_n  (RSTN),
        .push_i (push0_c),
        .din_i  (Q),
        .pop_i  (pop0_c),
        .dout_o (head0_c),
        .cnt_o  (cnt0_c)
    );

    mem_rsp_fifo #(.DW(DW), .RSP_D(RSP_D)) u_rsp_fifo1 (
        .clk    (CLK),
        .rst_n  (RSTN),
        .push_i (push1_c),
        .din_i  (Q),
        .pop_i  (pop1_c),
        .dout_o (head1_c),
        .cnt_o  (cnt1_c)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural M20K port model and a per-client response scoreboard.
// Honours MEM_ARB_WMASK_EN the same way as the design.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        REQ_VALID0, REQ_VALID1;
    logic        REQ_READY0, REQ_READY1;
    logic        REQ_WE0, REQ_WE1;
    logic [8:0]  REQ_ADDR0, REQ_ADDR1;
    logic [31:0] REQ_DATA0, REQ_DATA1;
`ifdef MEM_ARB_WMASK_EN
    logic [3:0]  REQ_BE0, REQ_BE1;
`endif
    logic        RSP_VALID0, RSP_VALID1;
    logic        RSP_READY0, RSP_READY1;
    logic [31:0] RSP_DATA0, RSP_DATA1;
    logic [8:0]  A;
    logic [31:0] D;
    logic        CE, WE;
    logic [31:0] WEM;
    logic [31:0] Q;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] macro_mem [512];
    logic [31:0] macro_q;
    logic [31:0] shadow [512];
    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];
    logic [31:0] m0, m1;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.AW(9), .DW(32), .RSP_D(2)) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .REQ_VALID0 (REQ_VALID0),
        .REQ_READY0 (REQ_READY0),
        .REQ_WE0    (REQ_WE0),
        .REQ_ADDR0  (REQ_ADDR0),
        .REQ_DATA0  (REQ_DATA0),
`ifdef MEM_ARB_WMASK_EN
        .REQ_BE0    (REQ_BE0),
        .REQ_BE1    (REQ_BE1),
`endif
        .REQ_VALID1 (REQ_VALID1),
        .REQ_READY1 (REQ_READY1),
        .REQ_WE1    (REQ_WE1),
        .REQ_ADDR1  (REQ_ADDR1),
        .REQ_DATA1  (REQ_DATA1),
        .RSP_VALID0 (RSP_VALID0),
        .RSP_READY0 (RSP_READY0),
        .RSP_DATA0  (RSP_DATA0),
        .RSP_VALID1 (RSP_VALID1),
        .RSP_READY1 (RSP_READY1),
        .RSP_DATA1  (RSP_DATA1),
        .A          (A),
        .D          (D),
        .CE         (CE),
        .WE         (WE),
        .WEM        (WEM),
        .Q          (Q)
    );

    // M20K port: registered inputs, NEW_DATA write-then-read, Q valid the cycle after a read.
    always @(posedge CLK) begin
        if (CE) begin
            if (WE) macro_mem[A] <= (macro_mem[A] & ~WEM) | (D & WEM);
            else    macro_q      <= macro_mem[A];
        end
    end
    assign Q = macro_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

`ifdef MEM_ARB_WMASK_EN
    function automatic logic [31:0] tb_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction
    assign m0 = tb_mask(REQ_BE0);
    assign m1 = tb_mask(REQ_BE1);
`else
    assign m0 = '1;
    assign m1 = '1;
`endif

    // Scoreboard: expected read data queued at acceptance, compared when the client takes a response.
    always @(negedge CLK) begin
        if (!RSTN) begin
            exp0.delete();
            exp1.delete();
        end else begin
            if (RSP_VALID0 && RSP_READY0) begin
                if (exp0.size() == 0) chk("rsp0_spurious", 32'(RSP_VALID0), 32'h0);
                else                  chk("rsp0_data", RSP_DATA0, exp0.pop_front());
            end
            if (RSP_VALID1 && RSP_READY1) begin
                if (exp1.size() == 0) chk("rsp1_spurious", 32'(RSP_VALID1), 32'h0);
                else                  chk("rsp1_data", RSP_DATA1, exp1.pop_front());
            end
            if (REQ_VALID0 && REQ_READY0) begin
                if (REQ_WE0) shadow[REQ_ADDR0] = (shadow[REQ_ADDR0] & ~m0) | (REQ_DATA0 & m0);
                else         exp0.push_back(shadow[REQ_ADDR0]);
            end
            if (REQ_VALID1 && REQ_READY1) begin
                if (REQ_WE1) shadow[REQ_ADDR1] = (shadow[REQ_ADDR1] & ~m1) | (REQ_DATA1 & m1);
                else         exp1.push_back(shadow[REQ_ADDR1]);
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_ready0"}, 32'(REQ_READY0), 32'h0);
        chk({pfx, "_ready1"}, 32'(REQ_READY1), 32'h0);
        chk({pfx, "_ce"},     32'(CE),         32'h0);
        chk({pfx, "_we"},     32'(WE),         32'h0);
        chk({pfx, "_a"},      32'(A),          32'h0);
        chk({pfx, "_d"},      D,               32'h0);
        chk({pfx, "_wem"},    WEM,             32'hFFFF_FFFF);
        chk({pfx, "_rspv0"},  32'(RSP_VALID0), 32'h0);
        chk({pfx, "_rspv1"},  32'(RSP_VALID1), 32'h0);
    endtask

    // One request held until accepted (bounded), then dropped.
    task automatic do_req(input int c, input logic we, input logic [8:0] addr,
                          input logic [31:0] data, input logic [3:0] be);
        int   n;
        logic ok;
        n = 0;
        if (c == 0) begin
            REQ_VALID0 = 1'b1; REQ_WE0 = we; REQ_ADDR0 = addr; REQ_DATA0 = data;
`ifdef MEM_ARB_WMASK_EN
            REQ_BE0 = be;
`endif
        end else begin
            REQ_VALID1 = 1'b1; REQ_WE1 = we; REQ_ADDR1 = addr; REQ_DATA1 = data;
`ifdef MEM_ARB_WMASK_EN
            REQ_BE1 = be;
`endif
        end
        do begin
            @(negedge CLK);
            ok = (c == 0) ? REQ_READY0 : REQ_READY1;
            n++;
            if (!ok) cyc();
        end while (!ok && n < 16);
        chk($sformatf("req_accept_c%0d_%03h", c, addr), 32'(ok), 32'h1);
        cyc();
        if (c == 0) REQ_VALID0 = 1'b0;
        else        REQ_VALID1 = 1'b0;
        if (be == 4'h0) n = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   a0, a1, acc, n;
        logic g0, g1;

        for (int i = 0; i < 512; i++) begin
            macro_mem[i] = '0;
            shadow[i]    = '0;
        end
        macro_q    = '0;
        RSTN       = 1'b0;
        REQ_VALID0 = 1'b1; REQ_WE0 = 1'b0; REQ_ADDR0 = 9'h1A5; REQ_DATA0 = '0;
        REQ_VALID1 = 1'b0; REQ_WE1 = 1'b0; REQ_ADDR1 = '0;     REQ_DATA1 = '0;
`ifdef MEM_ARB_WMASK_EN
        REQ_BE0 = 4'hF; REQ_BE1 = 4'hF;
`endif
        RSP_READY0 = 1'b1;
        RSP_READY1 = 1'b1;

        // Reset values with a request pending.
        @(negedge CLK);
        chk_reset_outputs("rst");
        cyc();
        REQ_VALID0 = 1'b0;
        RSTN       = 1'b1;
        cyc();

        // Single write then read by client 0.
        REQ_VALID0 = 1'b1; REQ_WE0 = 1'b1; REQ_ADDR0 = 9'h1A5; REQ_DATA0 = 32'hDEAD_BEEF;
        @(negedge CLK);
        chk("t2_wr_ready", 32'(REQ_READY0), 32'h1);
        chk("t2_wr_ce",    32'(CE),         32'h1);
        chk("t2_wr_we",    32'(WE),         32'h1);
        chk("t2_wr_a",     32'(A),          32'h1A5);
        chk("t2_wr_d",     D,               32'hDEAD_BEEF);
        cyc();
        REQ_WE0 = 1'b0;
        @(negedge CLK);
        chk("t2_rd_ready", 32'(REQ_READY0), 32'h1);
        chk("t2_rd_we",    32'(WE),         32'h0);
        chk("t2_rsp_early",32'(RSP_VALID0), 32'h0);
        cyc();
        REQ_VALID0 = 1'b0;
        @(negedge CLK);
        chk("t2_rsp_valid", 32'(RSP_VALID0), 32'h1);
        chk("t2_rsp_data",  RSP_DATA0,       32'hDEAD_BEEF);
        chk("t2_idle_ce",   32'(CE),         32'h0);
        cyc();
        @(negedge CLK);
        chk("t2_rsp_done", 32'(RSP_VALID0), 32'h0);
        cyc();

        // Contention: alternating grants, client 1 granted last so client 0 leads.
        for (int i = 0; i < 4; i++) begin
            do_req(0, 1'b1, 9'h010 + 9'(i), 32'hA000_0000 + 32'(i), 4'hF);
            do_req(1, 1'b1, 9'h020 + 9'(i), 32'hB000_0000 + 32'(i), 4'hF);
        end
        a0 = 0; a1 = 0;
        REQ_VALID0 = 1'b1; REQ_WE0 = 1'b0;
        REQ_VALID1 = 1'b1; REQ_WE1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            REQ_ADDR0 = 9'h010 + 9'(a0);
            REQ_ADDR1 = 9'h020 + 9'(a1);
            @(negedge CLK);
            chk($sformatf("t3_gnt0_k%0d", k), 32'(REQ_READY0), 32'((k % 2) == 0));
            chk($sformatf("t3_gnt1_k%0d", k), 32'(REQ_READY1), 32'((k % 2) == 1));
            if (REQ_READY0) a0++;
            if (REQ_READY1) a1++;
            cyc();
        end
        REQ_VALID0 = 1'b0;
        REQ_VALID1 = 1'b0;
        repeat (3) cyc();

        // Backpressure: client 1 stalls after two outstanding reads.
        RSP_READY1 = 1'b0;
        a1 = 0; acc = 0;
        REQ_VALID1 = 1'b1; REQ_WE1 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            REQ_ADDR1 = 9'h020 + 9'(a1);
            @(negedge CLK);
            if (REQ_READY1) begin acc++; a1++; end
            cyc();
        end
        chk("t4_accepted", 32'(acc), 32'd2);
        @(negedge CLK);
        chk("t4_stalled",  32'(REQ_READY1), 32'h0);
        chk("t4_rsp_valid",32'(RSP_VALID1), 32'h1);
        chk("t4_rsp_head", RSP_DATA1,       32'hB000_0000);
        cyc();
        RSP_READY1 = 1'b1;
        n = 0;
        while (acc < 4 && n < 20) begin
            REQ_ADDR1 = 9'h020 + 9'(a1);
            @(negedge CLK);
            if (REQ_READY1) begin acc++; a1++; end
            cyc();
            n++;
        end
        REQ_VALID1 = 1'b0;
        chk("t4_all_accepted", 32'(acc), 32'd4);
        repeat (4) cyc();

        // Byte-masked write.
        do_req(0, 1'b1, 9'h030, 32'hFFFF_FFFF, 4'hF);
        REQ_VALID0 = 1'b1; REQ_WE0 = 1'b1; REQ_ADDR0 = 9'h030; REQ_DATA0 = 32'h0;
`ifdef MEM_ARB_WMASK_EN
        REQ_BE0 = 4'b0101;
`endif
        @(negedge CLK);
        chk("t5_wr_ready", 32'(REQ_READY0), 32'h1);
`ifdef MEM_ARB_WMASK_EN
        chk("t5_wem", WEM, 32'h00FF_00FF);
`else
        chk("t5_wem", WEM, 32'hFFFF_FFFF);
`endif
        cyc();
        REQ_VALID0 = 1'b0;
        do_req(0, 1'b0, 9'h030, 32'h0, 4'hF);
        @(negedge CLK);
        chk("t5_rsp_valid", 32'(RSP_VALID0), 32'h1);
`ifdef MEM_ARB_WMASK_EN
        chk("t5_rsp_data", RSP_DATA0, 32'hFF00_FF00);
`else
        chk("t5_rsp_data", RSP_DATA0, 32'h0000_0000);
`endif
        cyc();

        // Client 0 write and client 1 read presented together.
        do_req(1, 1'b1, 9'h1FF, 32'hCAFE_F00D, 4'hF);
        REQ_VALID0 = 1'b1; REQ_WE0 = 1'b1; REQ_ADDR0 = 9'h000; REQ_DATA0 = 32'h1234_5678;
`ifdef MEM_ARB_WMASK_EN
        REQ_BE0 = 4'hF;
`endif
        REQ_VALID1 = 1'b1; REQ_WE1 = 1'b0; REQ_ADDR1 = 9'h1FF;
        g0 = 1'b0; g1 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            chk($sformatf("t6_one_grant_k%0d", k), 32'(REQ_READY0) + 32'(REQ_READY1), 32'd1);
            chk($sformatf("t6_no_rsp0_k%0d", k), 32'(RSP_VALID0), 32'h0);
            if (REQ_READY0) g0 = 1'b1;
            if (REQ_READY1) g1 = 1'b1;
            cyc();
            if (g0) REQ_VALID0 = 1'b0;
            if (g1) REQ_VALID1 = 1'b0;
        end
        chk("t6_both_served", {30'h0, g0, g1}, 32'h3);
        @(negedge CLK);
        chk("t6_rsp1_valid", 32'(RSP_VALID1), 32'h1);
        chk("t6_rsp1_data",  RSP_DATA1,       32'hCAFE_F00D);
        chk("t6_no_rsp0",    32'(RSP_VALID0), 32'h0);
        cyc();
        repeat (2) cyc();

        // Reset mid-traffic with client 0 buffer full.
        RSP_READY0 = 1'b0;
        REQ_VALID0 = 1'b1; REQ_WE0 = 1'b0; REQ_ADDR0 = 9'h1A5;
        repeat (3) cyc();
        @(negedge CLK);
        chk("t1_pre_rspv0", 32'(RSP_VALID0), 32'h1);
        cyc();
        RSTN = 1'b0;
        @(negedge CLK);
        chk_reset_outputs("t1_rst");
        cyc();
        REQ_VALID0 = 1'b0;
        RSP_READY0 = 1'b1;
        RSTN       = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk($sformatf("t1_post_rspv0_k%0d", k), 32'(RSP_VALID0), 32'h0);
            chk($sformatf("t1_post_ce_k%0d", k),    32'(CE),         32'h0);
            cyc();
        end

        chk("sb_empty0", 32'(exp0.size()), 32'h0);
        chk("sb_empty1", 32'(exp1.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
